// File: rtl/fb_writer_pkg.sv
// Shared types and default geometry for the PPU framebuffer writer.
package fb_writer_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ACTIVE    = 2'd1,
        FILL      = 2'd2,
        BLANKED   = 2'd3
    } state_e;

    localparam int WIDTH_DEF         = 160;
    localparam int HEIGHT_DEF        = 144;
    localparam int X_BITS_DEF        = 8;
    localparam int Y_BITS_DEF        = 8;
    localparam int PIXEL_BITS_DEF    = 2;
    localparam int DOUBLE_BUFFER_DEF = 1;
    localparam int COUNT_BITS_DEF    = 8;

    localparam int ADDR_BITS = DOUBLE_BUFFER_DEF + Y_BITS_DEF + X_BITS_DEF;

    // Write address is {bank, y, x}; the bank bit only exists when double buffered.
    function automatic int addr_bits(input int double_buffer, input int y_bits, input int x_bits);
        return ((double_buffer != 0) ? 1 : 0) + y_bits + x_bits;
    endfunction

endpackage

// File: rtl/ppu_framebuffer_writer_if.sv
// PPU pixel stream in, framebuffer write port out; the writer takes the slave side.
// No backpressure: one pixel and at most one write per cycle.
interface ppu_framebuffer_writer_if #(
    parameter int PIXEL_BITS = 2,
    parameter int ADDR_BITS  = 17
);
    logic [PIXEL_BITS-1:0] ppu_pixel;
    logic                  ppu_valid;
    logic                  ppu_hblank;
    logic                  ppu_vblank;
    logic                  ppu_lcd_enable;

    logic                  fb_write_en;
    logic [ADDR_BITS-1:0]  fb_write_addr;
    logic [PIXEL_BITS-1:0] fb_write_data;

    modport master (
        output ppu_pixel, ppu_valid, ppu_hblank, ppu_vblank, ppu_lcd_enable,
        input  fb_write_en, fb_write_addr, fb_write_data
    );

    modport slave (
        input  ppu_pixel, ppu_valid, ppu_hblank, ppu_vblank, ppu_lcd_enable,
        output fb_write_en, fb_write_addr, fb_write_data
    );
endinterface

// File: rtl/rise_fall_detect.sv
// Edge detector against a one-cycle-delayed copy; edges are valid in the same cycle as the new level.
// No backpressure; the delay register clears on reset, so a level already high at release reads as a rise.
module rise_fall_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);
    logic sig_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;
endmodule

// File: rtl/ppu_framebuffer_writer.sv
// PPU pixel stream to framebuffer writes with bank swap, frame checking and LCD-off blank fill.
// Outputs registered, one cycle after the accepted input; no backpressure, RAM takes one write per cycle.
module ppu_framebuffer_writer
    import fb_writer_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEF,
    parameter int HEIGHT        = HEIGHT_DEF,
    parameter int X_BITS        = X_BITS_DEF,
    parameter int Y_BITS        = Y_BITS_DEF,
    parameter int PIXEL_BITS    = PIXEL_BITS_DEF,
    parameter int DOUBLE_BUFFER = DOUBLE_BUFFER_DEF,
    parameter int BLANK_VALUE   = 0,
    parameter int COUNT_BITS    = COUNT_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ppu_framebuffer_writer_if.slave bus,
    output logic                  display_bank,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [COUNT_BITS-1:0] frame_count,
    output logic                  overflow_x,
    output logic                  overflow_y,
    output logic                  fill_busy
);
    localparam int ADDR_W = addr_bits(DOUBLE_BUFFER, Y_BITS, X_BITS);

    // Counters carry one extra bit so x == WIDTH and y == HEIGHT are representable.
    localparam logic [X_BITS:0]         X_END     = (X_BITS+1)'(WIDTH);
    localparam logic [X_BITS:0]         X_LAST    = (X_BITS+1)'(WIDTH - 1);
    localparam logic [Y_BITS:0]         Y_END     = (Y_BITS+1)'(HEIGHT);
    localparam logic [Y_BITS:0]         Y_LAST    = (Y_BITS+1)'(HEIGHT - 1);
    localparam logic [PIXEL_BITS-1:0]   BLANK_PIX = PIXEL_BITS'(BLANK_VALUE);

    state_e                  state_q, state_d;
    logic [X_BITS:0]         x_q, x_d;
    logic [Y_BITS:0]         y_q, y_d;
    logic                    bad_q, bad_d;
    logic                    wbank_q, wbank_d;
    logic                    dbank_q, dbank_d;
    logic [COUNT_BITS-1:0]   cnt_q, cnt_d;
    logic                    ovx_q, ovx_d;
    logic                    ovy_q, ovy_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [PIXEL_BITS-1:0]   data_q, data_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    fill_q, fill_d;
    logic                    swap;
    logic [ADDR_W-1:0]       pix_addr;

    logic hb_rise, vb_rise, le_rise, le_fall;
    logic unused_hb_fall, unused_vb_fall;

    rise_fall_detect u_hblank_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .sig_i  (bus.ppu_hblank),
        .rise_o (hb_rise),
        .fall_o (unused_hb_fall)
    );

    rise_fall_detect u_vblank_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .sig_i  (bus.ppu_vblank),
        .rise_o (vb_rise),
        .fall_o (unused_vb_fall)
    );

    rise_fall_detect u_lcd_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .sig_i  (bus.ppu_lcd_enable),
        .rise_o (le_rise),
        .fall_o (le_fall)
    );

    generate
        if (DOUBLE_BUFFER != 0) begin : g_banked
            assign pix_addr = {wbank_q, y_q[Y_BITS-1:0], x_q[X_BITS-1:0]};
        end else begin : g_single
            logic unused_wbank;
            assign unused_wbank = wbank_q;
            assign pix_addr     = {y_q[Y_BITS-1:0], x_q[X_BITS-1:0]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        bad_d   = bad_q;
        wbank_d = wbank_q;
        dbank_d = dbank_q;
        cnt_d   = cnt_q;
        ovx_d   = ovx_q;
        ovy_d   = ovy_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        fill_d  = 1'b0;
        swap    = 1'b0;

        case (state_q)
            WAIT_SYNC: begin
                if (vb_rise || le_rise) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    bad_d   = 1'b0;
                end
            end
            ACTIVE: begin
                // Event priority: lcd fall, vblank rise, vblank level, hblank rise, pixel.
                if (le_fall) begin
                    err_d   = 1'b1;
                    state_d = FILL;
                    x_d     = '0;
                    y_d     = '0;
                    bad_d   = 1'b0;
                end else if (vb_rise) begin
                    if (y_q == Y_END && !bad_q) begin
                        done_d = 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                        swap   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    x_d   = '0;
                    y_d   = '0;
                    bad_d = 1'b0;
                end else if (bus.ppu_vblank) begin
                    x_d = '0;
                    y_d = '0;
                end else if (hb_rise) begin
                    x_d = '0;
                    if (y_q < Y_END) begin
                        y_d = y_q + 1'b1;
                    end else begin
                        ovy_d = 1'b1;
                        bad_d = 1'b1;
                    end
                end else if (bus.ppu_valid && !bus.ppu_hblank) begin
                    if (x_q == X_END) begin
                        ovx_d = 1'b1;
                        bad_d = 1'b1;
                    end else begin
                        we_d   = 1'b1;
                        addr_d = pix_addr;
                        data_d = bus.ppu_pixel;
                        x_d    = x_q + 1'b1;
                    end
                end
            end
            FILL: begin
                // x/y double as the fill raster position; PPU input is ignored until done.
                we_d   = 1'b1;
                addr_d = pix_addr;
                data_d = BLANK_PIX;
                fill_d = 1'b1;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d     = '0;
                        swap    = 1'b1;
                        state_d = bus.ppu_lcd_enable ? ACTIVE : BLANKED;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            BLANKED: begin
                if (bus.ppu_lcd_enable) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    bad_d   = 1'b0;
                end
            end
            default: state_d = WAIT_SYNC;
        endcase

        if (swap && DOUBLE_BUFFER != 0) begin
            dbank_d = wbank_q;
            wbank_d = ~wbank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= WAIT_SYNC;
            x_q     <= '0;
            y_q     <= '0;
            bad_q   <= 1'b0;
            wbank_q <= (DOUBLE_BUFFER != 0);
            dbank_q <= 1'b0;
            cnt_q   <= '0;
            ovx_q   <= 1'b0;
            ovy_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            bad_q   <= bad_d;
            wbank_q <= wbank_d;
            dbank_q <= dbank_d;
            cnt_q   <= cnt_d;
            ovx_q   <= ovx_d;
            ovy_q   <= ovy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fill_q  <= fill_d;
        end
    end

    assign bus.fb_write_en   = we_q;
    assign bus.fb_write_addr = addr_q;
    assign bus.fb_write_data = data_q;
    assign display_bank      = dbank_q;
    assign frame_done        = done_q;
    assign frame_err         = err_q;
    assign frame_count       = cnt_q;
    assign overflow_x        = ovx_q;
    assign overflow_y        = ovy_q;
    assign fill_busy         = fill_q;
endmodule

// File: tb/tb_ppu_framebuffer_writer.sv
// Two writers (double-buffered 8-bit count, single-buffered 2-bit count) fed one random PPU stream.
module tb_ppu_framebuffer_writer;
    import fb_writer_pkg::*;

    localparam int W    = 8;
    localparam int H    = 5;
    localparam int XB   = 3;
    localparam int YB   = 3;
    localparam int PB   = 2;
    localparam int AW_A = addr_bits(1, YB, XB);
    localparam int AW_B = addr_bits(0, YB, XB);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [PB-1:0] pix;
    logic          vld, hbl, vbl, lcd;

    ppu_framebuffer_writer_if #(.PIXEL_BITS(PB), .ADDR_BITS(AW_A)) bus_a ();
    ppu_framebuffer_writer_if #(.PIXEL_BITS(PB), .ADDR_BITS(AW_B)) bus_b ();

    assign bus_a.ppu_pixel      = pix;
    assign bus_a.ppu_valid      = vld;
    assign bus_a.ppu_hblank     = hbl;
    assign bus_a.ppu_vblank     = vbl;
    assign bus_a.ppu_lcd_enable = lcd;
    assign bus_b.ppu_pixel      = pix;
    assign bus_b.ppu_valid      = vld;
    assign bus_b.ppu_hblank     = hbl;
    assign bus_b.ppu_vblank     = vbl;
    assign bus_b.ppu_lcd_enable = lcd;

    logic       db_a, done_a, err_a, ovx_a, ovy_a, fill_a;
    logic [7:0] cnt_a;
    logic       db_b, done_b, err_b, ovx_b, ovy_b, fill_b;
    logic [1:0] cnt_b;

    ppu_framebuffer_writer #(
        .WIDTH(W), .HEIGHT(H), .X_BITS(XB), .Y_BITS(YB), .PIXEL_BITS(PB),
        .DOUBLE_BUFFER(1), .BLANK_VALUE(0), .COUNT_BITS(8)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a),
        .display_bank(db_a), .frame_done(done_a), .frame_err(err_a), .frame_count(cnt_a),
        .overflow_x(ovx_a), .overflow_y(ovy_a), .fill_busy(fill_a)
    );

    ppu_framebuffer_writer #(
        .WIDTH(W), .HEIGHT(H), .X_BITS(XB), .Y_BITS(YB), .PIXEL_BITS(PB),
        .DOUBLE_BUFFER(0), .BLANK_VALUE(3), .COUNT_BITS(2)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b),
        .display_bank(db_b), .frame_done(done_b), .frame_err(err_b), .frame_count(cnt_b),
        .overflow_x(ovx_b), .overflow_y(ovy_b), .fill_busy(fill_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one entry per instance, 0 = banked/8-bit count, 1 = single/2-bit count.
    int m_mode[2];      // 0 wait-sync, 1 drawing, 2 filling, 3 blanked
    int m_col[2], m_row[2], m_fidx[2], m_cnt[2];
    bit m_bad[2], m_wb[2], m_db[2], m_ovx[2], m_ovy[2];
    bit m_phb[2], m_pvb[2], m_ple[2];
    bit e_we[2], e_done[2], e_err[2], e_fill[2];
    int e_addr[2], e_data[2];

    function automatic bit banked(input int k);
        return k == 0;
    endfunction

    function automatic int count_mod(input int k);
        return (k == 0) ? 256 : 4;
    endfunction

    function automatic int blank_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic int mkaddr(input int k, input bit bank, input int row, input int col);
        int a;
        a = ((row % (1 << YB)) << XB) + col;
        if (banked(k) && bank) a += 1 << (YB + XB);
        return a;
    endfunction

    task automatic model_swap(input int k);
        if (banked(k)) begin
            m_db[k] = m_wb[k];
            m_wb[k] = !m_wb[k];
        end
    endtask

    task automatic model_step(input int k);
        bit hr, vr, lr, lf;
        if (!reset_n) begin
            m_mode[k] = 0; m_col[k] = 0; m_row[k] = 0; m_fidx[k] = 0; m_cnt[k] = 0;
            m_bad[k] = 0; m_wb[k] = banked(k); m_db[k] = 0; m_ovx[k] = 0; m_ovy[k] = 0;
            m_phb[k] = 0; m_pvb[k] = 0; m_ple[k] = 0;
            e_we[k] = 0; e_done[k] = 0; e_err[k] = 0; e_fill[k] = 0;
            return;
        end
        hr = hbl && !m_phb[k];
        vr = vbl && !m_pvb[k];
        lr = lcd && !m_ple[k];
        lf = !lcd && m_ple[k];
        e_we[k] = 0; e_done[k] = 0; e_err[k] = 0; e_fill[k] = 0;
        case (m_mode[k])
            0: if (vr || lr) begin
                m_mode[k] = 1; m_col[k] = 0; m_row[k] = 0; m_bad[k] = 0;
            end
            1: begin
                if (lf) begin
                    e_err[k] = 1; m_mode[k] = 2; m_fidx[k] = 0;
                end else if (vr) begin
                    if (m_row[k] == H && !m_bad[k]) begin
                        e_done[k] = 1;
                        m_cnt[k]  = (m_cnt[k] + 1) % count_mod(k);
                        model_swap(k);
                    end else begin
                        e_err[k] = 1;
                    end
                    m_col[k] = 0; m_row[k] = 0; m_bad[k] = 0;
                end else if (vbl) begin
                    m_col[k] = 0; m_row[k] = 0;
                end else if (hr) begin
                    m_col[k] = 0;
                    if (m_row[k] < H) m_row[k]++;
                    else begin m_ovy[k] = 1; m_bad[k] = 1; end
                end else if (vld && !hbl) begin
                    if (m_col[k] == W) begin
                        m_ovx[k] = 1; m_bad[k] = 1;
                    end else begin
                        e_we[k] = 1;
                        e_addr[k] = mkaddr(k, m_wb[k], m_row[k], m_col[k]);
                        e_data[k] = int'(pix);
                        m_col[k]++;
                    end
                end
            end
            2: begin
                e_we[k] = 1; e_fill[k] = 1;
                e_addr[k] = mkaddr(k, m_wb[k], m_fidx[k] / W, m_fidx[k] % W);
                e_data[k] = blank_of(k);
                m_fidx[k]++;
                if (m_fidx[k] == W * H) begin
                    model_swap(k);
                    m_mode[k] = lcd ? 1 : 3;
                    m_col[k] = 0; m_row[k] = 0; m_bad[k] = 0;
                end
            end
            default: if (lcd) begin
                m_mode[k] = 1; m_col[k] = 0; m_row[k] = 0; m_bad[k] = 0;
            end
        endcase
        m_phb[k] = hbl; m_pvb[k] = vbl; m_ple[k] = lcd;
    endtask

    task automatic compare_inst(input int k, input string nm, input logic we,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic dbank, input logic done, input logic err,
                                input logic [31:0] cnt, input logic ovx, input logic ovy,
                                input logic fill);
        chk({nm, ".write_en"}, 32'(we), 32'(e_we[k]));
        if (e_we[k]) begin
            chk({nm, ".addr"}, addr, e_addr[k]);
            chk({nm, ".data"}, data, e_data[k]);
        end
        chk({nm, ".display_bank"}, 32'(dbank), 32'(m_db[k]));
        chk({nm, ".frame_done"}, 32'(done), 32'(e_done[k]));
        chk({nm, ".frame_err"}, 32'(err), 32'(e_err[k]));
        chk({nm, ".frame_count"}, cnt, m_cnt[k]);
        chk({nm, ".overflow_x"}, 32'(ovx), 32'(m_ovx[k]));
        chk({nm, ".overflow_y"}, 32'(ovy), 32'(m_ovy[k]));
        chk({nm, ".fill_busy"}, 32'(fill), 32'(e_fill[k]));
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_inst(0, "a", bus_a.fb_write_en, 32'(bus_a.fb_write_addr), 32'(bus_a.fb_write_data),
                     db_a, done_a, err_a, 32'(cnt_a), ovx_a, ovy_a, fill_a);
        compare_inst(1, "b", bus_b.fb_write_en, 32'(bus_b.fb_write_addr), 32'(bus_b.fb_write_data),
                     db_b, done_b, err_b, 32'(cnt_b), ovx_b, ovy_b, fill_b);
    endtask

    task automatic drive(input bit v, input bit h, input bit vb);
        pix = PB'($urandom);
        vld = v;
        hbl = h;
        vbl = vb;
        step();
    endtask

    task automatic send_line(input int npix);
        for (int i = 0; i < npix; i++) begin
            repeat ($urandom_range(0, 1)) drive(1'b0, 1'b0, 1'b0);
            drive(1'b1, 1'b0, 1'b0);
        end
        // A pixel coinciding with the hblank rise must be dropped.
        drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        repeat ($urandom_range(1, 3)) drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_vblank();
        repeat ($urandom_range(2, 4)) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int nlines, input int wide_line);
        for (int l = 0; l < nlines; l++) send_line((l == wide_line) ? W + 1 : W);
        send_vblank();
    endtask

    initial begin
        reset_n = 1'b0;
        lcd = 1'b0;
        pix = '0; vld = 1'b0; hbl = 1'b0; vbl = 1'b0;
        repeat (3) step();
        chk("reset.count_a", 32'(cnt_a), 0);
        chk("reset.write_en_a", 32'(bus_a.fb_write_en), 0);

        reset_n = 1'b1;
        lcd = 1'b1;
        step();
        send_vblank();
        repeat (6) send_frame(H, -1);
        send_frame(H, 0);
        send_frame(H, -1);
        send_frame(H + 1, -1);
        send_frame(H - 1, -1);
        send_frame(H, -1);

        // LCD off mid-frame, stay off through the whole fill, then back on.
        send_line(W); send_line(W); send_line(3);
        lcd = 1'b0;
        repeat (W * H + 6) drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        lcd = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) send_frame(H, -1);

        // LCD off then back on during the fill.
        send_line(W);
        lcd = 1'b0;
        repeat (10) drive(1'b1, 1'b0, 1'b0);
        lcd = 1'b1;
        repeat (W * H) drive(1'b1, 1'b0, 1'b0);
        send_frame(H, -1);

        // LCD fall coinciding with vblank rise: the fall wins.
        send_frame(H - 1, -1);
        for (int l = 0; l < H; l++) send_line(W);
        lcd = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        repeat (W * H + 3) drive(1'b1, 1'b0, 1'b0);
        lcd = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        send_frame(H, -1);

        // Reset during a pixel burst.
        send_line(W); send_line(W);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        repeat (2) drive(1'b1, 1'b0, 1'b0);
        chk("midreset.count_a", 32'(cnt_a), 0);
        chk("midreset.bank_a", 32'(db_a), 0);
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        send_vblank();
        repeat (2) send_frame(H, -1);

        // Unstructured stimulus with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) hbl = !hbl;
            if ($urandom_range(0, 59) == 0) vbl = !vbl;
            if ($urandom_range(0, 299) == 0) lcd = !lcd;
            reset_n = ($urandom_range(0, 999) != 0);
            pix = PB'($urandom);
            vld = 1'($urandom_range(0, 1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
